// File: rtl/alu_op_ctrl.sv
// Sequential front-end for the combinational alu: debounces the go button,
// issues registered operands/opcode, and captures the settled result and flags.
module alu_op_ctrl #(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 250000,
  parameter int SETTLE   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_a,
  input  logic [WIDTH-1:0] sw_b,
  input  logic [3:0]       sw_op,
  input  logic             go,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_cin,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err,
  output logic             busy,
  output logic             done
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int SW = $clog2(SETTLE + 1);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_MOD = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b1000;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t          state, state_next;
  logic            go_s1, go_s2, go_level, go_pulse;
  logic [DW-1:0]   deb_cnt;
  logic [SW-1:0]   settle_cnt;
  logic            issue, capture;
  logic            op_bad;
  logic            cap_c, cap_v;

  // The debounced level follows the synced button only after it has disagreed
  // for DEBOUNCE consecutive cycles; go_pulse fires on the edge it rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      go_s1    <= 1'b0;
      go_s2    <= 1'b0;
      go_level <= 1'b0;
      go_pulse <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      go_s1    <= go;
      go_s2    <= go_s1;
      go_pulse <= 1'b0;
      if (go_s2 != go_level) begin
        if (deb_cnt == DW'(DEBOUNCE - 1)) begin
          deb_cnt  <= '0;
          go_level <= go_s2;
          go_pulse <= go_s2;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: if (go_pulse) begin
        issue      = 1'b1;
        state_next = EXEC;
      end
      EXEC: if (settle_cnt == SW'(SETTLE - 1)) begin
        capture    = 1'b1;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Validity and flags are judged on the issued operands, not the live switches.
  always_comb begin
    op_bad = (alu_op < OP_ADD) || (alu_op > OP_XOR) ||
             (((alu_op == OP_DIV) || (alu_op == OP_MOD)) && (alu_b == '0));
    cap_c  = 1'b0;
    cap_v  = 1'b0;
    if (alu_op == OP_ADD) begin
      cap_c = alu_cout;
      cap_v = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_s[WIDTH-1] != alu_a[WIDTH-1]);
    end else if (alu_op == OP_SUB) begin
      cap_c = alu_cout;
      cap_v = (alu_b[WIDTH-1] != alu_a[WIDTH-1]) && (alu_s[WIDTH-1] != alu_b[WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      settle_cnt <= '0;
      result     <= '0;
      flag_n     <= 1'b0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      flag_v     <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (issue) begin
        alu_a      <= sw_a;
        alu_b      <= sw_b;
        alu_op     <= sw_op;
        settle_cnt <= '0;
      end else if (state == EXEC) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
      if (capture) begin
        if (op_bad) begin
          result <= '0;
          flag_n <= 1'b0;
          flag_z <= 1'b1;
          flag_c <= 1'b0;
          flag_v <= 1'b0;
          err    <= 1'b1;
        end else begin
          result <= alu_s;
          flag_n <= alu_s[WIDTH-1];
          flag_z <= (alu_s == '0);
          flag_c <= cap_c;
          flag_v <= cap_v;
          err    <= 1'b0;
        end
      end
    end
  end

  assign alu_cin = 1'b0;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_alu_op_ctrl.sv
// Directed bench for alu_op_ctrl with a behavioural stand-in for the lab alu;
// each task drives one scenario and checks against hand-computed values.
module tb_alu_op_ctrl;

  localparam int W   = 4;
  localparam int DEB = 4;
  localparam int SET = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw_a, sw_b;
  logic [3:0]   sw_op;
  logic         go;
  logic [W-1:0] alu_s;
  logic         alu_cout;
  logic [W-1:0] alu_a, alu_b;
  logic [3:0]   alu_op;
  logic         alu_cin;
  logic [W-1:0] result;
  logic         flag_n, flag_z, flag_c, flag_v, err, busy, done;

  int checks = 0;
  int errors = 0;

  alu_op_ctrl #(.WIDTH(W), .DEBOUNCE(DEB), .SETTLE(SET)) dut (
    .clk(clk), .rst(rst), .sw_a(sw_a), .sw_b(sw_b), .sw_op(sw_op), .go(go),
    .alu_s(alu_s), .alu_cout(alu_cout), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_cin(alu_cin), .result(result), .flag_n(flag_n),
    .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .err(err),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Stand-in for the lab alu: sub is B-A with Cout as the borrow.
  logic [7:0] prod;
  always_comb begin
    alu_s    = '0;
    alu_cout = 1'b0;
    prod     = {4'b0, alu_a} * {4'b0, alu_b};
    case (alu_op)
      4'b0001: {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0010: begin
        alu_s    = alu_b - alu_a;
        alu_cout = (alu_b < alu_a);
      end
      4'b0011: alu_s = prod[3:0];
      4'b0100: if (alu_b != 0) alu_s = alu_a / alu_b;
      4'b0101: if (alu_b != 0) alu_s = alu_a % alu_b;
      4'b0110: alu_s = alu_a & alu_b;
      4'b0111: alu_s = alu_a | alu_b;
      4'b1000: alu_s = alu_a ^ alu_b;
      default: alu_s = '0;
    endcase
  end

  // {result, N, Z, C, V, err}
  logic [W+4:0] obs_now;
  assign obs_now = {result, flag_n, flag_z, flag_c, flag_v, err};

  // Presses go with the given switches, holds it through the operation and
  // reports what was captured, then releases and lets the debouncer fall.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [3:0] op, output logic [W+4:0] obs,
                               output int busy_cycles, output int done_count,
                               output int first_busy);
    sw_a = a; sw_b = b; sw_op = op;
    obs = '0; busy_cycles = 0; done_count = 0; first_busy = -1;
    @(negedge clk);
    go = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (busy) begin
        busy_cycles++;
        if (first_busy < 0) first_busy = i;
      end
      if (done) begin
        done_count++;
        obs = obs_now;
      end
      if (done_count > 0 && !busy) break;
    end
    go = 1'b0;
    repeat (DEB + 4) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] all_out;
    all_out = {alu_a, alu_b, alu_op, alu_cin, result, flag_n, flag_z, flag_c,
               flag_v, err, busy, done, 7'b0};
    checks++;
    if (all_out !== 32'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h want 0", all_out);
    end
  endtask

  task automatic test_add();
    logic [W+4:0] obs; int bc, dc, fb;
    applyStimulus(4'd3, 4'd6, 4'b0001, obs, bc, dc, fb);
    checks++;
    if (dc !== 1) begin errors++; $display("[TB] FAIL add_done_count got %0d want 1", dc); end
    checks++;
    if (obs !== {4'b1001, 5'b10010}) begin errors++; $display("[TB] FAIL add_3_6 got %b want %b", obs, {4'b1001, 5'b10010}); end
    checks++;
    if (bc !== 3) begin errors++; $display("[TB] FAIL add_busy_cycles got %0d want 3", bc); end
    // go raised before edge 1: 2 sync + DEB debounce edges, then one more into EXEC
    checks++;
    if (fb !== 2 + DEB + 1) begin errors++; $display("[TB] FAIL go_latency got %0d want %0d", fb, 2 + DEB + 1); end
  endtask

  task automatic test_sub_overflow();
    logic [W+4:0] obs; int bc, dc, fb;
    applyStimulus(4'd15, 4'd1, 4'b0001, obs, bc, dc, fb);
    checks++;
    if (obs !== {4'b0000, 5'b01100}) begin errors++; $display("[TB] FAIL add_15_1 got %b want %b", obs, {4'b0000, 5'b01100}); end
    applyStimulus(4'd8, 4'd5, 4'b0010, obs, bc, dc, fb);
    checks++;
    if (obs !== {4'b1101, 5'b10110}) begin errors++; $display("[TB] FAIL sub_8_5 got %b want %b", obs, {4'b1101, 5'b10110}); end
    checks++;
    if (dc !== 1) begin errors++; $display("[TB] FAIL sub_done_count got %0d want 1", dc); end
  endtask

  task automatic test_errors();
    logic [W+4:0] obs; int bc, dc, fb;
    applyStimulus(4'd6, 4'd0, 4'b0100, obs, bc, dc, fb);
    checks++;
    if (obs !== {4'b0000, 5'b01001}) begin errors++; $display("[TB] FAIL div_by_zero got %b want %b", obs, {4'b0000, 5'b01001}); end
    checks++;
    if (bc !== 3) begin errors++; $display("[TB] FAIL err_busy_cycles got %0d want 3", bc); end
    applyStimulus(4'd9, 4'd3, 4'b1010, obs, bc, dc, fb);
    checks++;
    if (obs !== {4'b0000, 5'b01001}) begin errors++; $display("[TB] FAIL bad_opcode got %b want %b", obs, {4'b0000, 5'b01001}); end
    applyStimulus(4'd6, 4'd2, 4'b0100, obs, bc, dc, fb);
    checks++;
    if (obs !== {4'b0011, 5'b00000}) begin errors++; $display("[TB] FAIL div_6_2 got %b want %b", obs, {4'b0011, 5'b00000}); end
  endtask

  task automatic test_go_filtering();
    int seen_busy, dc;
    logic [W-1:0] res;
    seen_busy = 0;
    sw_a = 4'd1; sw_b = 4'd1; sw_op = 4'b0001;
    @(negedge clk); go = 1'b1;
    repeat (2) @(negedge clk);
    go = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (busy) seen_busy++;
    end
    checks++;
    if (seen_busy !== 0) begin errors++; $display("[TB] FAIL glitch_busy got %0d want 0", seen_busy); end

    dc = 0;
    go = 1'b1;
    repeat (40) begin @(negedge clk); if (done) dc++; end
    go = 1'b0;
    repeat (12) begin @(negedge clk); if (done) dc++; end
    checks++;
    if (dc !== 1) begin errors++; $display("[TB] FAIL hold_go_done_count got %0d want 1", dc); end

    // Operand switch moves while EXEC is running; capture must use the issued A.
    sw_a = 4'd2; sw_b = 4'd3; sw_op = 4'b0001;
    res = 'x;
    @(negedge clk); go = 1'b1;
    for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
    sw_a = 4'd7;
    for (int i = 0; i < 20; i++) begin
      if (done) begin res = result; break; end
      @(negedge clk);
    end
    go = 1'b0;
    repeat (DEB + 4) @(negedge clk);
    checks++;
    if (res !== 4'b0101) begin errors++; $display("[TB] FAIL switch_during_exec got %b want 0101", res); end
  endtask

  task automatic test_reset_mid_op();
    logic [W+4:0] obs; int bc, dc, fb;
    logic [31:0] all_out;
    sw_a = 4'd1; sw_b = 4'd2; sw_op = 4'b0001;
    @(negedge clk); go = 1'b1;
    for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1; go = 1'b0;
    @(negedge clk);
    all_out = {alu_a, alu_b, alu_op, alu_cin, result, flag_n, flag_z, flag_c,
               flag_v, err, busy, done, 7'b0};
    checks++;
    if (all_out !== 32'b0) begin errors++; $display("[TB] FAIL reset_mid_exec got %h want 0", all_out); end
    rst = 1'b0;
    dc = 0;
    repeat (10) begin @(negedge clk); if (done || busy) dc++; end
    checks++;
    if (dc !== 0) begin errors++; $display("[TB] FAIL reset_no_done got %0d want 0", dc); end
    applyStimulus(4'd12, 4'd6, 4'b0110, obs, bc, dc, fb);
    checks++;
    if (obs !== {4'b0100, 5'b00000}) begin errors++; $display("[TB] FAIL and_after_reset got %b want %b", obs, {4'b0100, 5'b00000}); end
  endtask

  task automatic test_or_stable();
    logic [W+4:0] obs; int bc, dc, fb;
    int drift;
    applyStimulus(4'd5, 4'd10, 4'b0111, obs, bc, dc, fb);
    checks++;
    if (obs !== {4'b1111, 5'b10000}) begin errors++; $display("[TB] FAIL or_5_10 got %b want %b", obs, {4'b1111, 5'b10000}); end
    drift = 0;
    for (int i = 0; i < 8; i++) begin
      sw_a = W'(i * 3); sw_b = W'(15 - i); sw_op = 4'(i);
      @(negedge clk);
      if (obs_now !== {4'b1111, 5'b10000}) drift++;
    end
    checks++;
    if (drift !== 0) begin errors++; $display("[TB] FAIL result_stable got %0d changes want 0", drift); end
  endtask

  initial begin
    rst = 1'b1; go = 1'b0;
    sw_a = '0; sw_b = '0; sw_op = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_add();
    test_sub_overflow();
    test_errors();
    test_go_filtering();
    test_reset_mid_op();
    test_or_stable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
